// File: rtl/id_ex_reg_if.sv
// ID/EX boundary bundle: decoded instruction from ID, MEM/WB forwarding taps,
// stall/flush from the hazard unit, and the EX-stage outputs toward the ALU.
interface id_ex_reg_if #(
    parameter int CPU_WIDTH    = 32,
    parameter int ALU_OP_WIDTH = 4
);
  logic                    stall;
  logic                    flush;
  logic                    id_valid;
  logic [CPU_WIDTH-1:0]    id_pc;
  logic [ALU_OP_WIDTH-1:0] id_alu_op;
  logic [CPU_WIDTH-1:0]    id_rs1_data;
  logic [CPU_WIDTH-1:0]    id_rs2_data;
  logic [CPU_WIDTH-1:0]    id_imm;
  logic [4:0]              id_rs1_addr;
  logic [4:0]              id_rs2_addr;
  logic [4:0]              id_rd_addr;
  logic                    id_src1_pc;
  logic                    id_src2_imm;
  logic                    id_reg_wen;
  logic                    id_mem_ren;
  logic                    id_mem_wen;
  logic                    mem_fwd_wen;
  logic                    wb_fwd_wen;
  logic [4:0]              mem_fwd_rd;
  logic [4:0]              wb_fwd_rd;
  logic [CPU_WIDTH-1:0]    mem_fwd_data;
  logic [CPU_WIDTH-1:0]    wb_fwd_data;
  logic                    ex_valid;
  logic                    ex_reg_wen;
  logic                    ex_mem_ren;
  logic                    ex_mem_wen;
  logic [CPU_WIDTH-1:0]    ex_pc;
  logic [ALU_OP_WIDTH-1:0] ex_alu_op;
  logic [4:0]              ex_rd_addr;
  logic [CPU_WIDTH-1:0]    alu_src1;
  logic [CPU_WIDTH-1:0]    alu_src2;
  logic [CPU_WIDTH-1:0]    ex_store_data;
  logic                    load_use;

  modport master (
    output stall, flush, id_valid, id_pc, id_alu_op, id_rs1_data, id_rs2_data,
           id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr, id_src1_pc, id_src2_imm,
           id_reg_wen, id_mem_ren, id_mem_wen, mem_fwd_wen, wb_fwd_wen,
           mem_fwd_rd, wb_fwd_rd, mem_fwd_data, wb_fwd_data,
    input  ex_valid, ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_pc, ex_alu_op,
           ex_rd_addr, alu_src1, alu_src2, ex_store_data, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_pc, id_alu_op, id_rs1_data, id_rs2_data,
           id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr, id_src1_pc, id_src2_imm,
           id_reg_wen, id_mem_ren, id_mem_wen, mem_fwd_wen, wb_fwd_wen,
           mem_fwd_rd, wb_fwd_rd, mem_fwd_data, wb_fwd_data,
    output ex_valid, ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_pc, ex_alu_op,
           ex_rd_addr, alu_src1, alu_src2, ex_store_data, load_use
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with MEM/WB operand forwarding and load-use detection.
// Flush beats stall beats load; stalled operands keep absorbing forwarded results.
module id_ex_reg #(
    parameter int                    CPU_WIDTH    = 32,
    parameter int                    ALU_OP_WIDTH = 4,
    parameter logic [ALU_OP_WIDTH-1:0] ALU_ADD    = {ALU_OP_WIDTH{1'b0}}
) (
    input logic        clk,
    input logic        rst_n,
    id_ex_reg_if.slave bus
);

  typedef struct packed {
    logic                    valid;
    logic                    reg_wen;
    logic                    mem_ren;
    logic                    mem_wen;
    logic                    src1_pc;
    logic                    src2_imm;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic [4:0]              rd_addr;
    logic [4:0]              rs1_addr;
    logic [4:0]              rs2_addr;
    logic [CPU_WIDTH-1:0]    pc;
    logic [CPU_WIDTH-1:0]    rs1_data;
    logic [CPU_WIDTH-1:0]    rs2_data;
    logic [CPU_WIDTH-1:0]    imm;
  } stage_t;

  // A bubble doubles as the reset image: everything zero except an ADD opcode.
  function automatic stage_t bubble();
    stage_t b;
    b        = '0;
    b.alu_op = ALU_ADD;
    return b;
  endfunction

  function automatic logic [CPU_WIDTH-1:0] fwd_sel(
      input logic [4:0]           addr,
      input logic [CPU_WIDTH-1:0] reg_data,
      input logic                 mem_wen,
      input logic [4:0]           mem_rd,
      input logic [CPU_WIDTH-1:0] mem_data,
      input logic                 wb_wen,
      input logic [4:0]           wb_rd,
      input logic [CPU_WIDTH-1:0] wb_data
  );
    logic [CPU_WIDTH-1:0] r;
    if (mem_wen && (mem_rd == addr) && (addr != 5'd0)) begin
      r = mem_data;
    end else if (wb_wen && (wb_rd == addr) && (addr != 5'd0)) begin
      r = wb_data;
    end else begin
      r = reg_data;
    end
    return r;
  endfunction

  stage_t               stage_r;
  stage_t               load_s;
  logic [CPU_WIDTH-1:0] fwd_rs1_s;
  logic [CPU_WIDTH-1:0] fwd_rs2_s;
  logic [CPU_WIDTH-1:0] alu_src1_s;
  logic [CPU_WIDTH-1:0] alu_src2_s;
  logic                 load_use_s;

  // Candidate next stage contents when loading from ID.
  always_comb begin
    load_s = bubble();
    if (bus.id_valid) begin
      load_s.valid    = 1'b1;
      load_s.reg_wen  = bus.id_reg_wen;
      load_s.mem_ren  = bus.id_mem_ren;
      load_s.mem_wen  = bus.id_mem_wen;
      load_s.src1_pc  = bus.id_src1_pc;
      load_s.src2_imm = bus.id_src2_imm;
      load_s.alu_op   = bus.id_alu_op;
      load_s.rd_addr  = bus.id_rd_addr;
      load_s.rs1_addr = bus.id_rs1_addr;
      load_s.rs2_addr = bus.id_rs2_addr;
      load_s.pc       = bus.id_pc;
      load_s.rs1_data = bus.id_rs1_data;
      load_s.rs2_data = bus.id_rs2_data;
      load_s.imm      = bus.id_imm;
    end else begin
      load_s = bubble();
    end
  end

  // Forwarded operands, ALU source muxing and the load-use hazard flag.
  always_comb begin
    fwd_rs1_s = fwd_sel(stage_r.rs1_addr, stage_r.rs1_data,
                        bus.mem_fwd_wen, bus.mem_fwd_rd, bus.mem_fwd_data,
                        bus.wb_fwd_wen, bus.wb_fwd_rd, bus.wb_fwd_data);
    fwd_rs2_s = fwd_sel(stage_r.rs2_addr, stage_r.rs2_data,
                        bus.mem_fwd_wen, bus.mem_fwd_rd, bus.mem_fwd_data,
                        bus.wb_fwd_wen, bus.wb_fwd_rd, bus.wb_fwd_data);
    if (stage_r.src1_pc) begin
      alu_src1_s = stage_r.pc;
    end else begin
      alu_src1_s = fwd_rs1_s;
    end
    if (stage_r.src2_imm) begin
      alu_src2_s = stage_r.imm;
    end else begin
      alu_src2_s = fwd_rs2_s;
    end
    // rs2 is compared even for instructions that do not read it.
    load_use_s = stage_r.valid && stage_r.mem_ren && (stage_r.rd_addr != 5'd0) &&
                 bus.id_valid &&
                 ((stage_r.rd_addr == bus.id_rs1_addr) ||
                  (stage_r.rd_addr == bus.id_rs2_addr));
  end

  // Stage register: flush > stall (operand refresh only) > load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_r <= bubble();
    end else if (bus.flush) begin
      stage_r <= bubble();
    end else if (bus.stall) begin
      stage_r.rs1_data <= fwd_rs1_s;
      stage_r.rs2_data <= fwd_rs2_s;
    end else begin
      stage_r <= load_s;
    end
  end

  assign bus.ex_valid      = stage_r.valid;
  assign bus.ex_reg_wen    = stage_r.reg_wen;
  assign bus.ex_mem_ren    = stage_r.mem_ren;
  assign bus.ex_mem_wen    = stage_r.mem_wen;
  assign bus.ex_pc         = stage_r.pc;
  assign bus.ex_alu_op     = stage_r.alu_op;
  assign bus.ex_rd_addr    = stage_r.rd_addr;
  assign bus.alu_src1      = alu_src1_s;
  assign bus.alu_src2      = alu_src2_s;
  assign bus.ex_store_data = fwd_rs2_s;
  assign bus.load_use      = load_use_s;

endmodule

// File: tb/tb_id_ex_reg.sv
// Scoreboard bench for id_ex_reg: stimulus queues hand-computed expectations,
// a negedge monitor pops one per cycle and compares against the EX outputs.
module tb_id_ex_reg;

  typedef struct {
    string       name;
    bit          ops;
    logic [31:0] pc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [31:0] st;
    logic        v;
    logic        rw;
    logic        mr;
    logic        mw;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        lu;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  id_ex_reg_if #(.CPU_WIDTH(32), .ALU_OP_WIDTH(4)) bus ();

  id_ex_reg #(.CPU_WIDTH(32), .ALU_OP_WIDTH(4), .ALU_ADD(4'd0)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=0x%0h required=0x%0h", n, f, act, req);
    end
  endtask

  // Monitor: one expectation per falling edge, well away from the active edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.ops) begin
        chk(e.name, "ex_pc", bus.ex_pc, e.pc);
        chk(e.name, "alu_src1", bus.alu_src1, e.s1);
        chk(e.name, "alu_src2", bus.alu_src2, e.s2);
        chk(e.name, "ex_store_data", bus.ex_store_data, e.st);
      end
      chk(e.name, "ex_valid", {31'd0, bus.ex_valid}, {31'd0, e.v});
      chk(e.name, "ex_reg_wen", {31'd0, bus.ex_reg_wen}, {31'd0, e.rw});
      chk(e.name, "ex_mem_ren", {31'd0, bus.ex_mem_ren}, {31'd0, e.mr});
      chk(e.name, "ex_mem_wen", {31'd0, bus.ex_mem_wen}, {31'd0, e.mw});
      chk(e.name, "ex_alu_op", {28'd0, bus.ex_alu_op}, {28'd0, e.op});
      chk(e.name, "ex_rd_addr", {27'd0, bus.ex_rd_addr}, {27'd0, e.rd});
      chk(e.name, "load_use", {31'd0, bus.load_use}, {31'd0, e.lu});
    end
  end

  task automatic push(input string n, input bit ops, input logic [31:0] pc, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] st, input logic v, input logic rw,
                      input logic mr, input logic mw, input logic [3:0] op, input logic [4:0] rd,
                      input logic lu);
    exp_t e;
    e.name = n; e.ops = ops; e.pc = pc; e.s1 = s1; e.s2 = s2; e.st = st;
    e.v = v; e.rw = rw; e.mr = mr; e.mw = mw; e.op = op; e.rd = rd; e.lu = lu;
    exp_q.push_back(e);
  endtask

  task automatic push_bubble(input string n);
    push(n, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [3:0] op,
                        input logic [4:0] rs1, input logic [31:0] d1,
                        input logic [4:0] rs2, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [4:0] rd,
                        input logic s1pc, input logic s2imm,
                        input logic rw, input logic mr, input logic mw);
    bus.id_valid = v; bus.id_pc = pc; bus.id_alu_op = op;
    bus.id_rs1_addr = rs1; bus.id_rs1_data = d1;
    bus.id_rs2_addr = rs2; bus.id_rs2_data = d2;
    bus.id_imm = imm; bus.id_rd_addr = rd;
    bus.id_src1_pc = s1pc; bus.id_src2_imm = s2imm;
    bus.id_reg_wen = rw; bus.id_mem_ren = mr; bus.id_mem_wen = mw;
  endtask

  task automatic set_fwd(input logic mw, input logic [4:0] mrd, input logic [31:0] md,
                         input logic ww, input logic [4:0] wrd, input logic [31:0] wd);
    bus.mem_fwd_wen = mw; bus.mem_fwd_rd = mrd; bus.mem_fwd_data = md;
    bus.wb_fwd_wen = ww; bus.wb_fwd_rd = wrd; bus.wb_fwd_data = wd;
  endtask

  task automatic idle_id();
    set_id(1'b0, 32'd0, 4'd0, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    idle_id();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    #1;
    push("reset", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // addi-like: rs1=x5=0x10, imm=4
    set_id(1'b1, 32'h100, 4'd0, 5'd5, 32'h10, 5'd6, 32'h77, 32'h4, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    push("load", 1'b1, 32'h100, 32'h10, 32'h4, 32'h77, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd8, 1'b0);
    set_id(1'b1, 32'h104, 4'd1, 5'd3, 32'h11, 5'd9, 32'h22, 32'h0, 5'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    // MEM and WB both target x3: MEM wins
    set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    push("fwd_mem", 1'b1, 32'h104, 32'hAA, 32'h22, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'd10, 1'b0);
    tick();
    set_fwd(1'b0, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    push("fwd_wb", 1'b1, 32'h104, 32'hBB, 32'h22, 32'h22, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1, 5'd10, 1'b0);
    // src1=PC, rs2=x0, store to memory
    set_id(1'b1, 32'h108, 4'd2, 5'd0, 32'd0, 5'd0, 32'd0, 32'h55, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    push("x0_guard", 1'b1, 32'h108, 32'h108, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 5'd0, 1'b0);
    // lw x7, 8(x2)
    set_id(1'b1, 32'h10C, 4'd0, 5'd2, 32'h1000, 5'd0, 32'd0, 32'h8, 5'd7, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    // add x1, x7, x2 behind the load
    set_id(1'b1, 32'h110, 4'd0, 5'd7, 32'h70, 5'd2, 32'h1000, 32'd0, 5'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    push("load_use", 1'b1, 32'h10C, 32'h1000, 32'h8, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd7, 1'b1);
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    bus.flush = 1'b1;
    push("stalled_lw", 1'b1, 32'h10C, 32'h1000, 32'h8, 32'd0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 5'd7, 1'b1);
    tick();
    bus.flush = 1'b0;
    idle_id();
    push_bubble("flush_bubble");
    set_id(1'b1, 32'h114, 4'd0, 5'd4, 32'h9, 5'd5, 32'h3, 32'd0, 5'd11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    // WB retires x4 during the first stall cycle only
    idle_id();
    bus.stall = 1'b1;
    set_fwd(1'b0, 5'd0, 32'd0, 1'b1, 5'd4, 32'h1234);
    push("stall_c1", 1'b1, 32'h114, 32'h1234, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd11, 1'b0);
    tick();
    set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    push("stall_c2", 1'b1, 32'h114, 32'h1234, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd11, 1'b0);
    tick();
    push("stall_kept", 1'b1, 32'h114, 32'h1234, 32'h3, 32'h3, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 5'd11, 1'b0);
    set_id(1'b1, 32'h200, 4'd3, 5'd6, 32'h66, 5'd0, 32'd0, 32'h7, 5'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    // reset asserted mid-cycle while stalled
    #2;
    rst_n = 1'b0;
    push("async_reset", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    bus.stall = 1'b0;
    push("post_release", 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 5'd0, 1'b0);
    tick();
    push("reload", 1'b1, 32'h200, 32'h66, 32'h7, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd3, 5'd12, 1'b0);
    idle_id();
    tick();
    push_bubble("idle_bubble");

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
